sa_cache_array: RTL
===================

# sa_cache_array

Parametrised N-way set-associative cache array with tag compare, per-set replacement, write-back/write-allocate policy and a miss-handling state machine. Sits between the core-side load/store port and the next-level memory. Owns valid/dirty/tag/data storage and sequences victim write-back and line fill on a miss.

## Interface
- SETS, 256: number of sets (power of two)
- WAYS, 4: associativity (power of two, ≥2)
- TAG_BITS, 18: tag width
- DATA_WIDTH, 32: word width
- LINE_WORDS, 16: words per line (power of two)
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- i_req_valid  in  1  request present
- o_req_ready  out  1  block can accept request (high only in IDLE)
- i_req_we  in  1  1 = store, 0 = load
- i_tag  in  TAG_BITS  request tag
- i_index  in  $clog2(SETS)  set index
- i_offset  in  $clog2(LINE_WORDS)  word within line
- i_wdata  in  DATA_WIDTH  store data
- o_resp_valid  out  1  one-cycle pulse, access complete
- o_rdata  out  DATA_WIDTH  load data (stores: the newly written word), valid with o_resp_valid
- o_cache_hit  out  1  qualifies o_resp_valid: 1 = hit, 0 = serviced after miss
- o_wb_valid  out  1  dirty victim write-back request
- o_wb_tag / o_wb_index  out  TAG_BITS / $clog2(SETS)  victim address
- o_wb_data  out  LINE_WORDS*DATA_WIDTH  victim line, word 0 in LSBs
- i_wb_ready  in  1  write-back accepted when o_wb_valid & i_wb_ready
- o_fill_req  out  1  line fill request
- o_fill_tag / o_fill_index  out  TAG_BITS / $clog2(SETS)  missed address
- i_fill_valid  in  1  fill data present; sampled only in FILL
- i_fill_data  in  LINE_WORDS*DATA_WIDTH  fill line, word 0 in LSBs

## Operation
- States: IDLE, LOOKUP, WRITEBACK, FILL, RESP.
- IDLE: o_req_ready=1; i_req_valid high → request registered, go LOOKUP.
- LOOKUP: WAYS parallel compares (valid & tag match). Hit: load reads word; store writes word, sets dirty; replacement updated; → RESP with hit=1. Miss: choose victim; victim valid & dirty → WRITEBACK, else → FILL.
- Victim: lowest-index invalid way; if all valid, per replacement policy (see Configuration).
- WRITEBACK: o_wb_valid held with stable tag/index/data until i_wb_ready; then → FILL.
- FILL: o_fill_req held until i_fill_valid. On that edge: line written to victim way, tag written, valid=1; store merges i_wdata at i_offset (overrides fill word) and sets dirty=1, load sets dirty=0; replacement updated; → RESP with hit=0.
- RESP: o_resp_valid=1 for exactly one cycle; → IDLE.
- Tag bits of a request never change while in flight; block has one outstanding request max.
- Reset: valid and dirty cleared in all sets/ways, replacement state to reset value, FSM to IDLE; data/tag arrays not reset. Reset in any state abandons the request: no response, o_wb_valid and o_fill_req drop next cycle.
- Reset values: o_req_ready=1; all other outputs 0.

## Timing
- Request accepted at edge N; LOOKUP in cycle N+1; hit → o_resp_valid in cycle N+2 (2-cycle hit latency).
- Clean miss: o_fill_req asserted cycle N+2; i_fill_valid at edge M → o_resp_valid in cycle M+1.
- Dirty miss: o_wb_valid from cycle N+2; handshake at edge K → o_fill_req from cycle K+1.
- i_fill_valid/i_wb_ready outside their state: ignored.
- Back-to-back: next request accepted earliest cycle after RESP (o_req_ready high again).

## Configuration
- SA_CACHE_LRU_EN defined: true LRU, $clog2(WAYS)-bit age per way per set; reset age of way w = w; accessed way → 0, ways with smaller age +1; victim = max-age way.
- Not defined: round-robin; one $clog2(WAYS)-bit pointer per set, reset 0; victim = pointer; pointer increments (wraps WAYS-1→0) only on fill into that set.

## Test plan
- Cold load tag=0x00001, index=5, offset=3; fill word3=0xDEADBEEF → o_fill_req, then o_resp_valid with hit=0, rdata=0xDEADBEEF; repeat → hit=1 in cycle N+2.
- Store 0x12345678 to hit line, then evict it by 4 more distinct tags in set 5 → o_wb_valid with that tag, wb_data word3=0x12345678; hold i_wb_ready low 5 cycles → outputs stable.
- Write miss tag=0x2, offset=0, wdata=0xA5A5A5A5, fill word0=0 → rdata=0xA5A5A5A5, line later written back with 0xA5A5A5A5.
- LRU (macro on): fill tags A,B,C,D in set 0, touch A, miss E → B evicted; macro off → A evicted.
- rst asserted during FILL → o_fill_req low next cycle, no o_resp_valid, subsequent lookup of any prior tag misses.
- i_fill_valid pulsed in IDLE → no state change, no array write.

Source files
------------

// File: rtl/sa_cache_array.sv
// N-way set-associative cache array: write-back / write-allocate, with a miss FSM for victim write-back and line fill.
// Define SA_CACHE_LRU_EN to select true LRU replacement; otherwise round-robin is used.
module sa_cache_array #(
    parameter int SETS       = 256,
    parameter int WAYS       = 4,
    parameter int TAG_BITS   = 18,
    parameter int DATA_WIDTH = 32,
    parameter int LINE_WORDS = 16
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             i_req_valid,
    output logic                             o_req_ready,
    input  logic                             i_req_we,
    input  logic [TAG_BITS-1:0]              i_tag,
    input  logic [$clog2(SETS)-1:0]          i_index,
    input  logic [$clog2(LINE_WORDS)-1:0]    i_offset,
    input  logic [DATA_WIDTH-1:0]            i_wdata,
    output logic                             o_resp_valid,
    output logic [DATA_WIDTH-1:0]            o_rdata,
    output logic                             o_cache_hit,
    output logic                             o_wb_valid,
    output logic [TAG_BITS-1:0]              o_wb_tag,
    output logic [$clog2(SETS)-1:0]          o_wb_index,
    output logic [LINE_WORDS*DATA_WIDTH-1:0] o_wb_data,
    input  logic                             i_wb_ready,
    output logic                             o_fill_req,
    output logic [TAG_BITS-1:0]              o_fill_tag,
    output logic [$clog2(SETS)-1:0]          o_fill_index,
    input  logic                             i_fill_valid,
    input  logic [LINE_WORDS*DATA_WIDTH-1:0] i_fill_data
);

    localparam int IDX_BITS  = $clog2(SETS);
    localparam int OFF_BITS  = $clog2(LINE_WORDS);
    localparam int WAY_BITS  = $clog2(WAYS);
    localparam int LINE_BITS = LINE_WORDS * DATA_WIDTH;

    typedef enum logic [2:0] {IDLE, LOOKUP, WRITEBACK, FILL, RESP} state_t;

    logic [LINE_BITS-1:0] data_mem  [SETS][WAYS];
    logic [TAG_BITS-1:0]  tag_mem   [SETS][WAYS];
    logic [WAYS-1:0]      valid_mem [SETS];
    logic [WAYS-1:0]      dirty_mem [SETS];

    state_t                state;
    logic                  req_we;
    logic [TAG_BITS-1:0]   req_tag;
    logic [IDX_BITS-1:0]   req_index;
    logic [OFF_BITS-1:0]   req_offset;
    logic [DATA_WIDTH-1:0] req_wdata;
    logic [WAY_BITS-1:0]   victim_way;

    logic                  hit;
    logic [WAY_BITS-1:0]   hit_way;
    logic [WAY_BITS-1:0]   invalid_way;
    logic [WAY_BITS-1:0]   policy_way;
    logic [WAY_BITS-1:0]   victim_sel;
    logic                  hit_done;
    logic                  fill_done;
    logic [LINE_BITS-1:0]  line_new;
    logic [WAY_BITS-1:0]   line_way;
    logic                  line_wr_en;
    logic [DATA_WIDTH-1:0] rd_word;

    // Parallel tag compare; descending scan so the lowest matching way wins.
    always_comb begin
        hit         = 1'b0;
        hit_way     = '0;
        invalid_way = '0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (valid_mem[req_index][w] && tag_mem[req_index][w] == req_tag) begin
                hit     = 1'b1;
                hit_way = WAY_BITS'(w);
            end
            if (!valid_mem[req_index][w])
                invalid_way = WAY_BITS'(w);
        end
    end

    assign victim_sel = (&valid_mem[req_index]) ? policy_way : invalid_way;
    assign hit_done   = (state == LOOKUP) && hit;
    assign fill_done  = (state == FILL) && i_fill_valid;

    // The new line is either the hit line or the fill line, with a store word merged in.
    always_comb begin
        line_way = (state == FILL) ? victim_way : hit_way;
        line_new = (state == FILL) ? i_fill_data : data_mem[req_index][hit_way];
        if (req_we)
            line_new[req_offset*DATA_WIDTH +: DATA_WIDTH] = req_wdata;
        rd_word    = line_new[req_offset*DATA_WIDTH +: DATA_WIDTH];
        line_wr_en = (hit_done && req_we) || fill_done;
    end

    always_ff @(posedge clk) begin
        if (line_wr_en && !rst)
            data_mem[req_index][line_way] <= line_new;
        if (fill_done && !rst)
            tag_mem[req_index][victim_way] <= req_tag;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int s = 0; s < SETS; s++) begin
                valid_mem[s] <= '0;
                dirty_mem[s] <= '0;
            end
        end else begin
            if (hit_done && req_we)
                dirty_mem[req_index][hit_way] <= 1'b1;
            if (fill_done) begin
                valid_mem[req_index][victim_way] <= 1'b1;
                dirty_mem[req_index][victim_way] <= req_we;
            end
        end
    end

`ifdef SA_CACHE_LRU_EN
    logic [WAY_BITS-1:0] age_mem [SETS][WAYS];
    logic                touch_en;
    logic [WAY_BITS-1:0] touch_way;

    // Ages in a set always form a permutation, so exactly one way holds WAYS-1.
    always_comb begin
        policy_way = '0;
        for (int w = 0; w < WAYS; w++)
            if (age_mem[req_index][w] == WAY_BITS'(WAYS - 1))
                policy_way = WAY_BITS'(w);
        touch_en  = hit_done || fill_done;
        touch_way = (state == FILL) ? victim_way : hit_way;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int s = 0; s < SETS; s++)
                for (int w = 0; w < WAYS; w++)
                    age_mem[s][w] <= WAY_BITS'(w);
        end else if (touch_en) begin
            for (int w = 0; w < WAYS; w++) begin
                if (WAY_BITS'(w) == touch_way)
                    age_mem[req_index][w] <= '0;
                else if (age_mem[req_index][w] < age_mem[req_index][touch_way])
                    age_mem[req_index][w] <= age_mem[req_index][w] + 1'b1;
            end
        end
    end
`else
    logic [WAY_BITS-1:0] rr_ptr [SETS];

    assign policy_way = rr_ptr[req_index];

    // The pointer advances only on fills; WAYS is a power of two so it wraps naturally.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int s = 0; s < SETS; s++)
                rr_ptr[s] <= '0;
        end else if (fill_done) begin
            rr_ptr[req_index] <= rr_ptr[req_index] + 1'b1;
        end
    end
`endif

    // Miss-handling FSM; every output is a register updated on state transitions.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            o_req_ready  <= 1'b1;
            o_resp_valid <= 1'b0;
            o_rdata      <= '0;
            o_cache_hit  <= 1'b0;
            o_wb_valid   <= 1'b0;
            o_wb_tag     <= '0;
            o_wb_index   <= '0;
            o_wb_data    <= '0;
            o_fill_req   <= 1'b0;
            o_fill_tag   <= '0;
            o_fill_index <= '0;
            req_we       <= 1'b0;
            req_tag      <= '0;
            req_index    <= '0;
            req_offset   <= '0;
            req_wdata    <= '0;
            victim_way   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (i_req_valid) begin
                        req_we      <= i_req_we;
                        req_tag     <= i_tag;
                        req_index   <= i_index;
                        req_offset  <= i_offset;
                        req_wdata   <= i_wdata;
                        o_req_ready <= 1'b0;
                        state       <= LOOKUP;
                    end
                end
                LOOKUP: begin
                    if (hit) begin
                        o_rdata      <= rd_word;
                        o_resp_valid <= 1'b1;
                        o_cache_hit  <= 1'b1;
                        state        <= RESP;
                    end else begin
                        victim_way   <= victim_sel;
                        o_fill_tag   <= req_tag;
                        o_fill_index <= req_index;
                        if (valid_mem[req_index][victim_sel] && dirty_mem[req_index][victim_sel]) begin
                            o_wb_valid <= 1'b1;
                            o_wb_tag   <= tag_mem[req_index][victim_sel];
                            o_wb_index <= req_index;
                            o_wb_data  <= data_mem[req_index][victim_sel];
                            state      <= WRITEBACK;
                        end else begin
                            o_fill_req <= 1'b1;
                            state      <= FILL;
                        end
                    end
                end
                WRITEBACK: begin
                    if (i_wb_ready) begin
                        o_wb_valid <= 1'b0;
                        o_fill_req <= 1'b1;
                        state      <= FILL;
                    end
                end
                FILL: begin
                    if (i_fill_valid) begin
                        o_fill_req   <= 1'b0;
                        o_rdata      <= rd_word;
                        o_resp_valid <= 1'b1;
                        o_cache_hit  <= 1'b0;
                        state        <= RESP;
                    end
                end
                RESP: begin
                    o_resp_valid <= 1'b0;
                    o_cache_hit  <= 1'b0;
                    o_req_ready  <= 1'b1;
                    state        <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
